// File: rtl/fitness_dispatch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fitness_dispatch_pkg
//  Description : Shared defaults, FSM encoding and helpers for the fitness
//                dispatcher and the fitness evaluator it feeds.
//  Revision    : 1.0 - initial release
// ============================================================================
package fitness_dispatch_pkg;

   localparam int DEF_POP_SIZE          = 50;
   localparam int DEF_IDX_WIDTH         = 8;
   localparam int DEF_DATA_WIDTH        = 4;
   localparam int DEF_NUM_PARTICLE_TYPE = 3;
   localparam int DEF_LATTICE_LENGTH    = 11;
   localparam int DEF_PARTICLE_LENGTH   = 2;
   localparam int DEF_SELF_FIT_LENGTH   = 10;

   // Generation FSM encoding
   localparam int STATE_W = 3;
   typedef logic [STATE_W-1:0] state_t;
   localparam state_t ST_IDLE    = 3'd0;
   localparam state_t ST_LOAD_IE = 3'd1;
   localparam state_t ST_LOAD_SE = 3'd2;
   localparam state_t ST_ISSUE   = 3'd3;
   localparam state_t ST_DRAIN   = 3'd4;

   // Address width needed to index `depth` entries (at least one bit)
   function automatic int idx_aw(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/fitness_dispatch_if.sv
`default_nettype none
// ============================================================================
//  Module      : fitness_dispatch_if
//  Description : Dispatcher <-> evaluator link: energy table streams,
//                individual issue and fitness writeback.
//  Revision    : 1.0 - initial release
// ============================================================================
interface fitness_dispatch_if
   import fitness_dispatch_pkg::*;
#(
   parameter int IDX_WIDTH         = DEF_IDX_WIDTH,
   parameter int DATA_WIDTH        = DEF_DATA_WIDTH,
   parameter int INDIVIDUAL_LENGTH = DEF_LATTICE_LENGTH*DEF_PARTICLE_LENGTH,
   parameter int SELF_FIT_LENGTH   = DEF_SELF_FIT_LENGTH
);
   logic [DATA_WIDTH-1:0]        self_energy_o;
   logic                         wrSelfEnergyValid_o;
   logic [DATA_WIDTH-1:0]        interact_energy_o;
   logic                         wrInteractEnergyValid_o;
   logic                         in_valid_o;
   logic [IDX_WIDTH-1:0]         ind_idx_o;
   logic [INDIVIDUAL_LENGTH-1:0] individual_vec_o;
   logic                         eval_valid_i;
   logic [SELF_FIT_LENGTH-1:0]   eval_energy_i;
   logic [IDX_WIDTH-1:0]         eval_idx_i;

   modport master (
      output self_energy_o, wrSelfEnergyValid_o,
      output interact_energy_o, wrInteractEnergyValid_o,
      output in_valid_o, ind_idx_o, individual_vec_o,
      input  eval_valid_i, eval_energy_i, eval_idx_i
   );

   modport slave (
      input  self_energy_o, wrSelfEnergyValid_o,
      input  interact_energy_o, wrInteractEnergyValid_o,
      input  in_valid_o, ind_idx_o, individual_vec_o,
      output eval_valid_i, eval_energy_i, eval_idx_i
   );
endinterface
`default_nettype wire

// File: rtl/fitness_dispatch_pop_mem.sv
`default_nettype none
// ============================================================================
//  Module      : pop_mem
//  Description : Population and fitness storage. Host write + issue read on
//                the population, evaluator write + host read on fitness.
//                Out-of-range indices are dropped on write, read back as 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module pop_mem
   import fitness_dispatch_pkg::*;
#(
   parameter int POP_SIZE          = DEF_POP_SIZE,
   parameter int IDX_WIDTH         = DEF_IDX_WIDTH,
   parameter int INDIVIDUAL_LENGTH = DEF_LATTICE_LENGTH*DEF_PARTICLE_LENGTH,
   parameter int SELF_FIT_LENGTH   = DEF_SELF_FIT_LENGTH
) (
   input  wire logic                         clk_i,
   input  wire logic                         host_wr_en_i,
   input  wire logic [IDX_WIDTH-1:0]         host_wr_idx_i,
   input  wire logic [INDIVIDUAL_LENGTH-1:0] host_wr_vec_i,
   input  wire logic [IDX_WIDTH-1:0]         iss_rd_idx_i,
   output logic      [INDIVIDUAL_LENGTH-1:0] iss_rd_vec_o,
   input  wire logic                         fit_wr_en_i,
   input  wire logic [IDX_WIDTH-1:0]         fit_wr_idx_i,
   input  wire logic [SELF_FIT_LENGTH-1:0]   fit_wr_data_i,
   input  wire logic [IDX_WIDTH-1:0]         fit_rd_idx_i,
   output logic      [SELF_FIT_LENGTH-1:0]   fit_rd_data_o
);
   localparam int                   c_aw      = idx_aw(POP_SIZE);
   localparam logic [IDX_WIDTH-1:0] c_pop_cnt = IDX_WIDTH'(POP_SIZE);

   logic [INDIVIDUAL_LENGTH-1:0] pop_q [POP_SIZE];
   logic [SELF_FIT_LENGTH-1:0]   fit_q [POP_SIZE];

   logic w_host_ok;
   logic w_fit_ok;

   assign w_host_ok = host_wr_en_i && (host_wr_idx_i < c_pop_cnt);
   assign w_fit_ok  = fit_wr_en_i  && (fit_wr_idx_i  < c_pop_cnt);

   // Storage writes; contents are intentionally not reset
   always_ff @(posedge clk_i) begin
      if (w_host_ok) pop_q[host_wr_idx_i[c_aw-1:0]] <= host_wr_vec_i;
      if (w_fit_ok)  fit_q[fit_wr_idx_i[c_aw-1:0]]  <= fit_wr_data_i;
   end

   assign iss_rd_vec_o  = (iss_rd_idx_i < c_pop_cnt) ? pop_q[iss_rd_idx_i[c_aw-1:0]] : '0;
   assign fit_rd_data_o = (fit_rd_idx_i < c_pop_cnt) ? fit_q[fit_rd_idx_i[c_aw-1:0]] : '0;

endmodule
`default_nettype wire

// File: rtl/fitness_dispatch.sv
`default_nettype none
// ============================================================================
//  Module      : fitness_dispatch
//  Description : Runs one GA generation: streams the interaction and
//                self-energy tables to the evaluator, issues every individual,
//                collects fitness writebacks and tracks the best individual.
//  Revision    : 1.0 - initial release
// ============================================================================
module fitness_dispatch
   import fitness_dispatch_pkg::*;
#(
   parameter int POP_SIZE          = DEF_POP_SIZE,
   parameter int IDX_WIDTH         = DEF_IDX_WIDTH,
   parameter int DATA_WIDTH        = DEF_DATA_WIDTH,
   parameter int NUM_PARTICLE_TYPE = DEF_NUM_PARTICLE_TYPE,
   parameter int LATTICE_LENGTH    = DEF_LATTICE_LENGTH,
   parameter int PARTICLE_LENGTH   = DEF_PARTICLE_LENGTH,
   parameter int INDIVIDUAL_LENGTH = LATTICE_LENGTH*PARTICLE_LENGTH,
   parameter int SELF_FIT_LENGTH   = DEF_SELF_FIT_LENGTH
) (
   input  wire logic                                            clk_i,
   input  wire logic                                            rst_n,
   input  wire logic                                            start_i,
   input  wire logic [NUM_PARTICLE_TYPE*DATA_WIDTH-1:0]         cfg_se_i,
   input  wire logic [NUM_PARTICLE_TYPE*NUM_PARTICLE_TYPE*DATA_WIDTH-1:0] cfg_ie_i,
   input  wire logic                                            pop_wr_en_i,
   input  wire logic [IDX_WIDTH-1:0]                            pop_wr_idx_i,
   input  wire logic [INDIVIDUAL_LENGTH-1:0]                    pop_wr_vec_i,
   fitness_dispatch_if.master                                   ev,
   input  wire logic [IDX_WIDTH-1:0]                            fit_rd_idx_i,
   output logic      [SELF_FIT_LENGTH-1:0]                      fit_rd_data_o,
   output logic                                                 busy_o,
   output logic                                                 done_ff_o,
   output logic      [IDX_WIDTH-1:0]                            best_idx_ff_o,
   output logic      [SELF_FIT_LENGTH-1:0]                      best_energy_ff_o
);
   localparam int                   c_n_se     = NUM_PARTICLE_TYPE;
   localparam int                   c_n_ie     = NUM_PARTICLE_TYPE*NUM_PARTICLE_TYPE;
   localparam int                   c_se_aw    = idx_aw(c_n_se);
   localparam int                   c_ie_aw    = idx_aw(c_n_ie);
   localparam logic [IDX_WIDTH-1:0] c_pop_cnt  = IDX_WIDTH'(POP_SIZE);
   localparam logic [IDX_WIDTH-1:0] c_pop_last = IDX_WIDTH'(POP_SIZE-1);
   localparam logic [IDX_WIDTH-1:0] c_se_last  = IDX_WIDTH'(c_n_se-1);
   localparam logic [IDX_WIDTH-1:0] c_ie_last  = IDX_WIDTH'(c_n_ie-1);

   state_t                              state_q, state_d;
   logic [IDX_WIDTH-1:0]                cnt_q, cnt_d;
   logic [IDX_WIDTH-1:0]                wb_cnt_q, wb_cnt_d;
   logic [c_n_se*DATA_WIDTH-1:0]        se_tbl_q, se_tbl_d;
   logic [c_n_ie*DATA_WIDTH-1:0]        ie_tbl_q, ie_tbl_d;
   logic [IDX_WIDTH-1:0]                best_idx_q, best_idx_d;
   logic [SELF_FIT_LENGTH-1:0]          best_energy_q, best_energy_d;
   logic                                done_q, done_d;
   logic                                in_valid_q, in_valid_d;
   logic [IDX_WIDTH-1:0]                ind_idx_q, ind_idx_d;
   logic [INDIVIDUAL_LENGTH-1:0]        ivec_q, ivec_d;

   logic                                w_start;
   logic                                w_wb_ok;
   logic                                w_finish;
   logic [INDIVIDUAL_LENGTH-1:0]        w_rd_vec;
   logic [DATA_WIDTH-1:0]               w_se_arr [c_n_se];
   logic [DATA_WIDTH-1:0]               w_ie_arr [c_n_ie];
   logic [DATA_WIDTH-1:0]               w_se_data, w_ie_data;
   logic                                w_se_vld, w_ie_vld;

   assign w_start = start_i && (state_q == ST_IDLE);
   assign w_wb_ok = ev.eval_valid_i && (ev.eval_idx_i < c_pop_cnt);

   // Entry 0 sits at the MSBs of each latched table
   for (genvar k = 0; k < c_n_se; k++) begin : g_se_view
      assign w_se_arr[k] = se_tbl_q[(c_n_se-1-k)*DATA_WIDTH +: DATA_WIDTH];
   end
   for (genvar k = 0; k < c_n_ie; k++) begin : g_ie_view
      assign w_ie_arr[k] = ie_tbl_q[(c_n_ie-1-k)*DATA_WIDTH +: DATA_WIDTH];
   end

   pop_mem #(
      .POP_SIZE          (POP_SIZE),
      .IDX_WIDTH         (IDX_WIDTH),
      .INDIVIDUAL_LENGTH (INDIVIDUAL_LENGTH),
      .SELF_FIT_LENGTH   (SELF_FIT_LENGTH)
   ) u_pop_mem (
      .clk_i         (clk_i),
      .host_wr_en_i  (pop_wr_en_i && (state_q == ST_IDLE)),
      .host_wr_idx_i (pop_wr_idx_i),
      .host_wr_vec_i (pop_wr_vec_i),
      .iss_rd_idx_i  (cnt_q),
      .iss_rd_vec_o  (w_rd_vec),
      .fit_wr_en_i   (ev.eval_valid_i),
      .fit_wr_idx_i  (ev.eval_idx_i),
      .fit_wr_data_i (ev.eval_energy_i),
      .fit_rd_idx_i  (fit_rd_idx_i),
      .fit_rd_data_o (fit_rd_data_o)
   );

   // State and datapath registers
   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         cnt_q         <= '0;
         wb_cnt_q      <= '0;
         se_tbl_q      <= '0;
         ie_tbl_q      <= '0;
         best_idx_q    <= '0;
         best_energy_q <= '0;
         done_q        <= 1'b0;
         in_valid_q    <= 1'b0;
         ind_idx_q     <= '0;
         ivec_q        <= '0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         wb_cnt_q      <= wb_cnt_d;
         se_tbl_q      <= se_tbl_d;
         ie_tbl_q      <= ie_tbl_d;
         best_idx_q    <= best_idx_d;
         best_energy_q <= best_energy_d;
         done_q        <= done_d;
         in_valid_q    <= in_valid_d;
         ind_idx_q     <= ind_idx_d;
         ivec_q        <= ivec_d;
      end
   end

   // Writeback bookkeeping: start clears first, a same-cycle writeback then counts
   always_comb begin
      wb_cnt_d      = w_start ? '0 : wb_cnt_q;
      best_energy_d = w_start ? '1 : best_energy_q;
      best_idx_d    = best_idx_q;
      se_tbl_d      = w_start ? cfg_se_i : se_tbl_q;
      ie_tbl_d      = w_start ? cfg_ie_i : ie_tbl_q;
      if (w_wb_ok) begin
         if (wb_cnt_d != c_pop_cnt) wb_cnt_d = wb_cnt_d + 1'b1;
         if (ev.eval_energy_i < best_energy_d) begin
            best_energy_d = ev.eval_energy_i;
            best_idx_d    = ev.eval_idx_i;
         end
      end
   end

   // Generation completes once issue is over and the final writeback lands
   assign w_finish = ((state_q == ST_DRAIN) ||
                      ((state_q == ST_ISSUE) && (cnt_q == c_pop_last))) &&
                     (wb_cnt_d == c_pop_cnt);

   // Next-state and phase counter
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               state_d = ST_LOAD_IE;
               cnt_d   = '0;
            end
         end
         ST_LOAD_IE: begin
            if (cnt_q == c_ie_last) begin
               state_d = ST_LOAD_SE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_LOAD_SE: begin
            if (cnt_q == c_se_last) begin
               state_d = ST_ISSUE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_ISSUE: begin
            if (cnt_q == c_pop_last) begin
               state_d = w_finish ? ST_IDLE : ST_DRAIN;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_DRAIN: begin
            if (w_finish) state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // Phase outputs: table streams, registered issue port and done pulse
   always_comb begin
      w_ie_vld   = (state_q == ST_LOAD_IE);
      w_se_vld   = (state_q == ST_LOAD_SE);
      w_ie_data  = w_ie_vld ? w_ie_arr[cnt_q[c_ie_aw-1:0]] : '0;
      w_se_data  = w_se_vld ? w_se_arr[cnt_q[c_se_aw-1:0]] : '0;
      in_valid_d = (state_q == ST_ISSUE);
      ind_idx_d  = in_valid_d ? cnt_q : '0;
      ivec_d     = in_valid_d ? w_rd_vec : '0;
      done_d     = w_finish;
   end

   assign ev.interact_energy_o       = w_ie_data;
   assign ev.wrInteractEnergyValid_o = w_ie_vld;
   assign ev.self_energy_o           = w_se_data;
   assign ev.wrSelfEnergyValid_o     = w_se_vld;
   assign ev.in_valid_o              = in_valid_q;
   assign ev.ind_idx_o               = ind_idx_q;
   assign ev.individual_vec_o        = ivec_q;
   assign busy_o                     = (state_q != ST_IDLE);
   assign done_ff_o                  = done_q;
   assign best_idx_ff_o              = best_idx_q;
   assign best_energy_ff_o           = best_energy_q;

endmodule
`default_nettype wire

// File: tb/tb_fitness_dispatch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fitness_dispatch
//  Description : Directed self-checking bench for fitness_dispatch.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fitness_dispatch;
   localparam int POP = 50;
   localparam int IW  = 8;
   localparam int DW  = 4;
   localparam int NPT = 3;
   localparam int IL  = 22;
   localparam int SFL = 10;

   logic                   clk_i        = 1'b0;
   logic                   rst_n        = 1'b0;
   logic                   start_i      = 1'b0;
   logic [NPT*DW-1:0]      cfg_se_i     = '0;
   logic [NPT*NPT*DW-1:0]  cfg_ie_i     = '0;
   logic                   pop_wr_en_i  = 1'b0;
   logic [IW-1:0]          pop_wr_idx_i = '0;
   logic [IL-1:0]          pop_wr_vec_i = '0;
   logic [IW-1:0]          fit_rd_idx_i = '0;
   logic [SFL-1:0]         fit_rd_data_o;
   logic                   busy_o;
   logic                   done_ff_o;
   logic [IW-1:0]          best_idx_ff_o;
   logic [SFL-1:0]         best_energy_ff_o;

   fitness_dispatch_if #(
      .IDX_WIDTH(IW), .DATA_WIDTH(DW), .INDIVIDUAL_LENGTH(IL), .SELF_FIT_LENGTH(SFL)
   ) ev_if ();

   fitness_dispatch #(
      .POP_SIZE(POP), .IDX_WIDTH(IW), .DATA_WIDTH(DW), .NUM_PARTICLE_TYPE(NPT),
      .LATTICE_LENGTH(11), .PARTICLE_LENGTH(2), .SELF_FIT_LENGTH(SFL)
   ) dut (
      .clk_i            (clk_i),
      .rst_n            (rst_n),
      .start_i          (start_i),
      .cfg_se_i         (cfg_se_i),
      .cfg_ie_i         (cfg_ie_i),
      .pop_wr_en_i      (pop_wr_en_i),
      .pop_wr_idx_i     (pop_wr_idx_i),
      .pop_wr_vec_i     (pop_wr_vec_i),
      .ev               (ev_if),
      .fit_rd_idx_i     (fit_rd_idx_i),
      .fit_rd_data_o    (fit_rd_data_o),
      .busy_o           (busy_o),
      .done_ff_o        (done_ff_o),
      .best_idx_ff_o    (best_idx_ff_o),
      .best_energy_ff_o (best_energy_ff_o)
   );

   always #5 clk_i = ~clk_i;

   int errors = 0;
   int checks = 0;
   logic [IL-1:0] exp_pop [POP];

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   function automatic logic [SFL-1:0] loop_energy(input int idx);
      return (idx % 10 == 4) ? SFL'(2) : SFL'(100 + idx);
   endfunction

   task automatic test_reset();
      rst_n = 1'b0;
      ev_if.eval_valid_i  = 1'b0;
      ev_if.eval_idx_i    = '0;
      ev_if.eval_energy_i = '0;
      tick();
      tick();
      checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy_o); end
      checks++; if (done_ff_o !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done_ff_o); end
      checks++; if (best_energy_ff_o !== '0) begin errors++; $display("FAIL reset_best_energy got=%0d exp=0", best_energy_ff_o); end
      checks++; if (ev_if.in_valid_o !== 1'b0) begin errors++; $display("FAIL reset_in_valid got=%b exp=0", ev_if.in_valid_o); end
      checks++; if ({ev_if.wrInteractEnergyValid_o, ev_if.wrSelfEnergyValid_o} !== 2'b00) begin
         errors++; $display("FAIL reset_stream_valids got=%b%b exp=00", ev_if.wrInteractEnergyValid_o, ev_if.wrSelfEnergyValid_o); end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic load_population();
      for (int i = 0; i < POP; i++) begin
         exp_pop[i]   = IL'(i * 98765 + 321);
         pop_wr_en_i  = 1'b1;
         pop_wr_idx_i = IW'(i);
         pop_wr_vec_i = exp_pop[i];
         tick();
      end
      pop_wr_en_i = 1'b0;
   endtask

   task automatic test_streams();
      cfg_se_i = {4'd1, 4'd2, 4'd3};
      cfg_ie_i = {4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9};
      start_i  = 1'b1;
      tick();
      start_i  = 1'b0;
      cfg_se_i = '1;
      cfg_ie_i = '1;
      for (int k = 0; k < NPT*NPT; k++) begin
         checks++;
         if (ev_if.wrInteractEnergyValid_o !== 1'b1 || ev_if.wrSelfEnergyValid_o !== 1'b0 ||
             ev_if.interact_energy_o !== DW'(k + 1)) begin
            errors++;
            $display("FAIL ie_beat%0d got vld=%b se_vld=%b data=%0d exp vld=1 se_vld=0 data=%0d",
                     k, ev_if.wrInteractEnergyValid_o, ev_if.wrSelfEnergyValid_o, ev_if.interact_energy_o, k + 1);
         end
         tick();
      end
      for (int k = 0; k < NPT; k++) begin
         checks++;
         if (ev_if.wrSelfEnergyValid_o !== 1'b1 || ev_if.wrInteractEnergyValid_o !== 1'b0 ||
             ev_if.self_energy_o !== DW'(k + 1)) begin
            errors++;
            $display("FAIL se_beat%0d got vld=%b ie_vld=%b data=%0d exp vld=1 ie_vld=0 data=%0d",
                     k, ev_if.wrSelfEnergyValid_o, ev_if.wrInteractEnergyValid_o, ev_if.self_energy_o, k + 1);
         end
         tick();
      end
      checks++;
      if ({ev_if.wrInteractEnergyValid_o, ev_if.wrSelfEnergyValid_o} !== 2'b00 ||
          ev_if.interact_energy_o !== '0 || ev_if.self_energy_o !== '0) begin
         errors++;
         $display("FAIL streams_idle got vld=%b%b ie=%0d se=%0d exp 00/0/0",
                  ev_if.wrInteractEnergyValid_o, ev_if.wrSelfEnergyValid_o, ev_if.interact_energy_o, ev_if.self_energy_o);
      end
   endtask

   task automatic test_issue();
      int wait_cyc = 0;
      while (ev_if.in_valid_o !== 1'b1 && wait_cyc < 5) begin tick(); wait_cyc++; end
      checks++; if (ev_if.in_valid_o !== 1'b1) begin errors++; $display("FAIL issue_start timeout got=%b exp=1", ev_if.in_valid_o); end
      checks++; if (best_energy_ff_o !== 10'h3FF) begin errors++; $display("FAIL best_init got=%0d exp=1023", best_energy_ff_o); end
      for (int i = 0; i < POP; i++) begin
         checks++;
         if (ev_if.in_valid_o !== 1'b1 || ev_if.ind_idx_o !== IW'(i) || ev_if.individual_vec_o !== exp_pop[i]) begin
            errors++;
            $display("FAIL issue%0d got vld=%b idx=%0d vec=%h exp vld=1 idx=%0d vec=%h",
                     i, ev_if.in_valid_o, ev_if.ind_idx_o, ev_if.individual_vec_o, i, exp_pop[i]);
         end
         tick();
      end
      checks++;
      if (ev_if.in_valid_o !== 1'b0 || busy_o !== 1'b1) begin
         errors++; $display("FAIL issue_end got vld=%b busy=%b exp vld=0 busy=1", ev_if.in_valid_o, busy_o);
      end
      // a host write while busy must not land
      pop_wr_en_i  = 1'b1;
      pop_wr_idx_i = IW'(3);
      pop_wr_vec_i = ~exp_pop[3];
      tick();
      pop_wr_en_i  = 1'b0;
   endtask

   task automatic wb(input int idx, input int energy);
      ev_if.eval_valid_i  = 1'b1;
      ev_if.eval_idx_i    = IW'(idx);
      ev_if.eval_energy_i = SFL'(energy);
      tick();
      ev_if.eval_valid_i  = 1'b0;
   endtask

   task automatic test_best_tie();
      wb(7, 5);
      checks++; if (best_idx_ff_o !== IW'(7) || best_energy_ff_o !== SFL'(5)) begin
         errors++; $display("FAIL best_first got idx=%0d e=%0d exp idx=7 e=5", best_idx_ff_o, best_energy_ff_o); end
      wb(9, 5);
      checks++; if (best_idx_ff_o !== IW'(7) || best_energy_ff_o !== SFL'(5)) begin
         errors++; $display("FAIL best_tie got idx=%0d e=%0d exp idx=7 e=5", best_idx_ff_o, best_energy_ff_o); end
   endtask

   task automatic test_done_and_start_ignored();
      int sent = 2;
      for (int i = 0; i < POP - 1; i++) begin
         if (i != 7 && i != 9) begin wb(i, 20); sent++; end
      end
      wb(60, 1);
      checks++; if (sent != 49 || done_ff_o !== 1'b0 || busy_o !== 1'b1) begin
         errors++; $display("FAIL no_done_at_49 got done=%b busy=%b sent=%0d exp done=0 busy=1 sent=49", done_ff_o, busy_o, sent); end
      checks++; if (best_idx_ff_o !== IW'(7) || best_energy_ff_o !== SFL'(5)) begin
         errors++; $display("FAIL best_after_drop got idx=%0d e=%0d exp idx=7 e=5", best_idx_ff_o, best_energy_ff_o); end
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
      tick();
      checks++; if (ev_if.wrInteractEnergyValid_o !== 1'b0 || busy_o !== 1'b1 || done_ff_o !== 1'b0) begin
         errors++; $display("FAIL start_in_drain got ie_vld=%b busy=%b done=%b exp 0/1/0",
                            ev_if.wrInteractEnergyValid_o, busy_o, done_ff_o); end
      wb(49, 30);
      checks++; if (done_ff_o !== 1'b1 || busy_o !== 1'b0) begin
         errors++; $display("FAIL done_pulse got done=%b busy=%b exp done=1 busy=0", done_ff_o, busy_o); end
      tick();
      checks++; if (done_ff_o !== 1'b0) begin errors++; $display("FAIL done_one_cycle got=%b exp=0", done_ff_o); end
      fit_rd_idx_i = IW'(7); #1;
      checks++; if (fit_rd_data_o !== SFL'(5)) begin errors++; $display("FAIL fit_rd7 got=%0d exp=5", fit_rd_data_o); end
      fit_rd_idx_i = IW'(49); #1;
      checks++; if (fit_rd_data_o !== SFL'(30)) begin errors++; $display("FAIL fit_rd49 got=%0d exp=30", fit_rd_data_o); end
      fit_rd_idx_i = IW'(60); #1;
      checks++; if (fit_rd_data_o !== '0) begin errors++; $display("FAIL fit_rd60 got=%0d exp=0", fit_rd_data_o); end
   endtask

   task automatic test_reset_mid_issue();
      int wait_cyc = 0;
      cfg_se_i = {4'd4, 4'd5, 4'd6};
      cfg_ie_i = {4'd9, 4'd8, 4'd7, 4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1};
      start_i  = 1'b1;
      tick();
      start_i  = 1'b0;
      while (ev_if.in_valid_o !== 1'b1 && wait_cyc < 20) begin tick(); wait_cyc++; end
      checks++; if (ev_if.in_valid_o !== 1'b1) begin errors++; $display("FAIL gen2_issue timeout got=%b exp=1", ev_if.in_valid_o); end
      tick(); tick(); tick();
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (ev_if.in_valid_o !== 1'b0 || ev_if.ind_idx_o !== '0 || ev_if.individual_vec_o !== '0 ||
          busy_o !== 1'b0 || done_ff_o !== 1'b0 || best_idx_ff_o !== '0 || best_energy_ff_o !== '0 ||
          ev_if.wrInteractEnergyValid_o !== 1'b0 || ev_if.wrSelfEnergyValid_o !== 1'b0) begin
         errors++;
         $display("FAIL async_reset got vld=%b idx=%0d vec=%h busy=%b done=%b bidx=%0d be=%0d exp all 0",
                  ev_if.in_valid_o, ev_if.ind_idx_o, ev_if.individual_vec_o, busy_o, done_ff_o,
                  best_idx_ff_o, best_energy_ff_o);
      end
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_loopback_gen();
      int issued  = 0;
      int bad_iss = 0;
      int got     = 0;
      cfg_se_i = {4'd4, 4'd5, 4'd6};
      cfg_ie_i = {4'd9, 4'd8, 4'd7, 4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1};
      start_i  = 1'b1;
      tick();
      start_i  = 1'b0;
      checks++; if (ev_if.wrInteractEnergyValid_o !== 1'b1 || ev_if.interact_energy_o !== DW'(9)) begin
         errors++; $display("FAIL gen3_ie0 got vld=%b data=%0d exp vld=1 data=9",
                            ev_if.wrInteractEnergyValid_o, ev_if.interact_energy_o); end
      for (int cyc = 0; cyc < 200 && got == 0; cyc++) begin
         if (done_ff_o === 1'b1) got = 1;
         if (ev_if.in_valid_o === 1'b1) begin
            if (ev_if.ind_idx_o !== IW'(issued) || ev_if.individual_vec_o !== exp_pop[issued]) bad_iss++;
            ev_if.eval_valid_i  = 1'b1;
            ev_if.eval_idx_i    = ev_if.ind_idx_o;
            ev_if.eval_energy_i = loop_energy(int'(ev_if.ind_idx_o));
            issued++;
         end else begin
            ev_if.eval_valid_i = 1'b0;
         end
         if (got == 0) tick();
      end
      ev_if.eval_valid_i = 1'b0;
      checks++; if (got != 1) begin errors++; $display("FAIL gen3_done timeout got=%0d exp=1", got); end
      checks++; if (issued != POP || bad_iss != 0) begin
         errors++; $display("FAIL gen3_issue got issued=%0d bad=%0d exp issued=50 bad=0", issued, bad_iss); end
      checks++; if (best_idx_ff_o !== IW'(4) || best_energy_ff_o !== SFL'(2) || busy_o !== 1'b0) begin
         errors++; $display("FAIL gen3_best got idx=%0d e=%0d busy=%b exp idx=4 e=2 busy=0",
                            best_idx_ff_o, best_energy_ff_o, busy_o); end
   endtask

   initial begin
      ev_if.eval_valid_i  = 1'b0;
      ev_if.eval_idx_i    = '0;
      ev_if.eval_energy_i = '0;
      test_reset();
      load_population();
      test_streams();
      test_issue();
      test_best_tie();
      test_done_and_start_ignored();
      test_reset_mid_issue();
      test_loopback_gen();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

endmodule
`default_nettype wire
